// File: rtl/i2cmb_regs_pkg.sv
// Register map, command codes and bit positions of the I2CMB Wishbone register file.
// Shared between the RTL and the WB master BFM.
package i2cmb_regs_pkg;

  typedef enum logic [1:0] {
    ADDR_CSR  = 2'd0,
    ADDR_DPR  = 2'd1,
    ADDR_CMDR = 2'd2,
    ADDR_FSMR = 2'd3
  } wb_addr_e;

  typedef enum logic [2:0] {
    CMD_WAIT    = 3'b000,
    CMD_WRITE   = 3'b001,
    CMD_RD_ACK  = 3'b010,
    CMD_RD_NAK  = 3'b011,
    CMD_START   = 3'b100,
    CMD_STOP    = 3'b101,
    CMD_SET_BUS = 3'b110,
    CMD_ILLEGAL = 3'b111
  } cmd_e;

  localparam int CSR_E_BIT    = 7;
  localparam int CSR_IE_BIT   = 6;
  localparam int CSR_BB_BIT   = 5;
  localparam int CSR_BC_BIT   = 4;
  localparam int CMDR_DON_BIT = 7;
  localparam int CMDR_NAK_BIT = 6;
  localparam int CMDR_AL_BIT  = 5;
  localparam int CMDR_ERR_BIT = 4;

  localparam logic [7:0] ENABLE_CORE_INTERRUPT = 8'hC0;
  localparam logic [7:0] DISABLE_CORE          = 8'h00;

  function automatic logic is_read_cmd(input logic [2:0] code);
    return (code == CMD_RD_ACK) || (code == CMD_RD_NAK);
  endfunction

endpackage

// File: rtl/i2cmb_cmd_issue.sv
// Command issue FSM: turns CMDR writes into a held valid/ready request to the byte FSM
// and latches completion status, received data and the selected bus id.
module i2cmb_cmd_issue
  import i2cmb_regs_pkg::*;
#(
  parameter int NUM_BUSES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       core_en_i,
  input  logic       irq_en_i,
  input  logic       abort_i,
  input  logic       cmdr_wr_i,
  input  logic       cmdr_rd_i,
  input  logic [2:0] cmdr_code_i,
  input  logic [7:0] dpr_tx_i,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [2:0] cmd_code_o,
  output logic [7:0] cmd_data_o,
  input  logic       done_i,
  input  logic [3:0] done_status_i,
  input  logic [7:0] rx_data_i,
  output logic [3:0] status_o,
  output logic [7:0] dpr_rx_o,
  output logic [3:0] bus_id_o,
  output logic       irq_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BUSY} state_e;

  localparam logic [7:0] BUS_LIMIT = 8'(NUM_BUSES);

  state_e state_r;
  logic   legal_s;

  assign legal_s = (cmdr_code_i != CMD_ILLEGAL) &&
                   !((cmdr_code_i == CMD_SET_BUS) && (dpr_tx_i >= BUS_LIMIT));

  // Command FSM with held request, status/irq latching and abort on core disable.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      cmd_valid_o <= 1'b0;
      cmd_code_o  <= 3'b000;
      cmd_data_o  <= 8'h00;
      status_o    <= 4'b1000;
      dpr_rx_o    <= 8'h00;
      bus_id_o    <= 4'h0;
      irq_o       <= 1'b0;
    end else if (abort_i) begin
      state_r     <= ST_IDLE;
      cmd_valid_o <= 1'b0;
      status_o    <= 4'b0000;
      bus_id_o    <= 4'h0;
      irq_o       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmdr_rd_i) begin
            status_o[2:0] <= 3'b000;
            irq_o         <= 1'b0;
          end
          if (cmdr_wr_i && core_en_i) begin
            cmd_code_o <= cmdr_code_i;
            if (legal_s) begin
              status_o    <= 4'b0000;
              irq_o       <= 1'b0;
              cmd_data_o  <= dpr_tx_i;
              cmd_valid_o <= 1'b1;
              state_r     <= ST_REQ;
            end else begin
              status_o <= 4'b1001;
              irq_o    <= irq_en_i;
            end
          end
        end
        ST_REQ: begin
          if (cmdr_rd_i) begin
            status_o[2:0] <= 3'b000;
            irq_o         <= 1'b0;
          end
          if (cmdr_wr_i && core_en_i) begin
            status_o[0] <= 1'b1;
            irq_o       <= irq_en_i;
          end
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            state_r     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (done_i) begin
            // Completion takes priority over a coincident CMDR read.
            status_o <= done_status_i;
            irq_o    <= irq_en_i;
            if (is_read_cmd(cmd_code_o)) begin
              dpr_rx_o <= rx_data_i;
            end
            if ((cmd_code_o == CMD_SET_BUS) && !done_status_i[0]) begin
              bus_id_o <= cmd_data_o[3:0];
            end
            state_r <= ST_IDLE;
          end else begin
            if (cmdr_rd_i) begin
              status_o[2:0] <= 3'b000;
              irq_o         <= 1'b0;
            end
            if (cmdr_wr_i && core_en_i) begin
              status_o[0] <= 1'b1;
              irq_o       <= irq_en_i;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/i2cmb_wb_regs.sv
// Wishbone slave register file of the I2CMB core: WB decode, single-cycle ack,
// CSR/DPR registers and read-back mux; command issue lives in i2cmb_cmd_issue.
module i2cmb_wb_regs
  import i2cmb_regs_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BUSES  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o,
  output logic                  core_en_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [2:0]            cmd_code_o,
  output logic [7:0]            cmd_data_o,
  input  logic                  done_i,
  input  logic [3:0]            done_status_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  bus_busy_i,
  input  logic                  bus_captured_i,
  input  logic [7:0]            fsm_state_i
);

  logic                  req_s, wr_s, rd_s, cmdr_wr_s, cmdr_rd_s, abort_s;
  wb_addr_e              addr_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic [3:0]            status_s, bus_id_s;
  logic [7:0]            dpr_rx_s;
  logic                  csr_e_r, csr_ie_r;
  logic [7:0]            dpr_tx_r;

  assign addr_s    = wb_addr_e'(adr_i);
  assign req_s     = cyc_i & stb_i & ~ack_o;
  assign wr_s      = req_s & we_i;
  assign rd_s      = req_s & ~we_i;
  assign cmdr_wr_s = wr_s && (addr_s == ADDR_CMDR);
  assign cmdr_rd_s = rd_s && (addr_s == ADDR_CMDR);
  // Clearing E while enabled tears down any command in flight.
  assign abort_s   = wr_s && (addr_s == ADDR_CSR) && csr_e_r && !dat_i[CSR_E_BIT];
  assign core_en_o = csr_e_r;

  // Read-back mux for the addressed register.
  always_comb begin
    rdata_s = 8'h00;
    case (addr_s)
      ADDR_CSR: begin
        rdata_s[CSR_E_BIT]  = csr_e_r;
        rdata_s[CSR_IE_BIT] = csr_ie_r;
        rdata_s[CSR_BB_BIT] = bus_busy_i;
        rdata_s[CSR_BC_BIT] = bus_captured_i;
        rdata_s[3:0]        = bus_id_s;
      end
      ADDR_DPR:  rdata_s = dpr_rx_s;
      ADDR_CMDR: begin
        rdata_s[CMDR_DON_BIT] = status_s[3];
        rdata_s[CMDR_NAK_BIT] = status_s[2];
        rdata_s[CMDR_AL_BIT]  = status_s[1];
        rdata_s[CMDR_ERR_BIT] = status_s[0];
        rdata_s[2:0]          = cmd_code_o;
      end
      ADDR_FSMR: rdata_s = fsm_state_i;
      default:   rdata_s = 8'h00;
    endcase
  end

  // WB ack/read data and the CSR/DPR write registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_o    <= 1'b0;
      dat_o    <= 8'h00;
      csr_e_r  <= 1'b0;
      csr_ie_r <= 1'b0;
      dpr_tx_r <= 8'h00;
    end else begin
      ack_o <= req_s;
      dat_o <= rd_s ? rdata_s : 8'h00;
      if (wr_s) begin
        case (addr_s)
          ADDR_CSR: begin
            csr_e_r  <= dat_i[CSR_E_BIT];
            csr_ie_r <= dat_i[CSR_IE_BIT];
          end
          ADDR_DPR: dpr_tx_r <= dat_i;
          default:  ;
        endcase
      end
    end
  end

  i2cmb_cmd_issue #(.NUM_BUSES(NUM_BUSES)) u_cmd_issue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_en_i    (csr_e_r),
    .irq_en_i     (csr_ie_r),
    .abort_i      (abort_s),
    .cmdr_wr_i    (cmdr_wr_s),
    .cmdr_rd_i    (cmdr_rd_s),
    .cmdr_code_i  (dat_i[2:0]),
    .dpr_tx_i     (dpr_tx_r),
    .cmd_valid_o  (cmd_valid_o),
    .cmd_ready_i  (cmd_ready_i),
    .cmd_code_o   (cmd_code_o),
    .cmd_data_o   (cmd_data_o),
    .done_i       (done_i),
    .done_status_i(done_status_i),
    .rx_data_i    (rx_data_i),
    .status_o     (status_s),
    .dpr_rx_o     (dpr_rx_s),
    .bus_id_o     (bus_id_s),
    .irq_o        (irq_o)
  );

endmodule

// File: tb/tb_i2cmb_wb_regs.sv
// Self-checking bench for i2cmb_wb_regs: directed register/command scenarios followed by
// randomized command traffic, checked against a transaction-level model of the register map.
module tb_i2cmb_wb_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0] adr = 2'd0;
  logic [7:0] wdat = 8'h00;
  logic [7:0] rdat;
  logic       ack, irq, core_en, valid;
  logic       ready = 1'b0;
  logic [2:0] code;
  logic [7:0] cdata;
  logic       done = 1'b0;
  logic [3:0] dstat = 4'h0;
  logic [7:0] rx = 8'h00;
  logic       bb = 1'b0, bc = 1'b0;
  logic [7:0] fsm_state = 8'h3C;

  int n_pass = 0;
  int n_total = 0;
  int hs_count = 0;

  // Model of the programmer-visible state.
  logic       m_e, m_ie, m_irq, m_busy;
  logic [7:0] m_dpr_tx, m_dpr_rx, m_pend_data;
  logic [3:0] m_status, m_bus_id;
  logic [2:0] m_cmd, m_pend_code;
  int         m_reqs;

  i2cmb_wb_regs dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr),
    .dat_i(wdat), .dat_o(rdat), .ack_o(ack), .irq_o(irq), .core_en_o(core_en),
    .cmd_valid_o(valid), .cmd_ready_i(ready), .cmd_code_o(code), .cmd_data_o(cdata),
    .done_i(done), .done_status_i(dstat), .rx_data_i(rx), .bus_busy_i(bb),
    .bus_captured_i(bc), .fsm_state_i(fsm_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (valid && ready) hs_count++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_e = 1'b0; m_ie = 1'b0; m_irq = 1'b0; m_busy = 1'b0;
    m_dpr_tx = 8'h00; m_dpr_rx = 8'h00; m_pend_data = 8'h00;
    m_status = 4'b1000; m_bus_id = 4'h0; m_cmd = 3'd0; m_pend_code = 3'd0;
    m_reqs = hs_count;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {m_e, m_ie, bb, bc, m_bus_id};
      2'd1:    return m_dpr_rx;
      2'd2:    return {m_status, 1'b0, m_cmd};
      default: return fsm_state;
    endcase
  endfunction

  task automatic model_write(input logic [1:0] a, input logic [7:0] d);
    case (a)
      2'd0: begin
        if (m_e && !d[7]) begin
          m_busy = 1'b0; m_status = 4'b0000; m_irq = 1'b0; m_bus_id = 4'h0;
        end
        m_e = d[7]; m_ie = d[6];
      end
      2'd1: m_dpr_tx = d;
      2'd2: if (m_e) begin
        if (m_busy) begin
          m_status[0] = 1'b1; m_irq = m_ie;
        end else begin
          m_cmd = d[2:0];
          if (d[2:0] == 3'd7 || (d[2:0] == 3'd6 && m_dpr_tx >= 8'd16)) begin
            m_status = 4'b1001; m_irq = m_ie;
          end else begin
            m_status = 4'b0000; m_irq = 1'b0; m_busy = 1'b1;
            m_pend_code = d[2:0]; m_pend_data = m_dpr_tx;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [7:0] d,
                         output logic [7:0] q);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk); #1;
    check("ack_rise", {7'd0, ack}, 8'h01);
    q = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("ack_fall", {7'd0, ack}, 8'h00);
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    wb_xfer(1'b1, a, d, q);
    model_write(a, d);
  endtask

  task automatic wb_rd(input string tag, input logic [1:0] a);
    logic [7:0] q, exp;
    exp = model_read(a);
    wb_xfer(1'b0, a, 8'h00, q);
    check(tag, q, exp);
    if (a == 2'd2) begin
      m_status[2:0] = 3'b000; m_irq = 1'b0;
    end
  endtask

  task automatic grant(input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("valid_hold", {7'd0, valid}, 8'h01);
      check("code_hold", {5'd0, code}, {5'd0, m_pend_code});
      check("data_hold", cdata, m_pend_data);
    end
    @(negedge clk);
    ready = 1'b1;
    check("valid_at_hs", {7'd0, valid}, 8'h01);
    check("code_at_hs", {5'd0, code}, {5'd0, m_pend_code});
    check("data_at_hs", cdata, m_pend_data);
    @(posedge clk); #1;
    check("valid_drop", {7'd0, valid}, 8'h00);
    @(negedge clk);
    ready = 1'b0;
    m_reqs++;
  endtask

  task automatic pulse_done(input logic [3:0] st, input logic [7:0] d);
    @(negedge clk);
    done = 1'b1; dstat = st; rx = d;
    @(posedge clk); #1;
    if (m_busy) begin
      m_status = st;
      if (m_pend_code == 3'd2 || m_pend_code == 3'd3) m_dpr_rx = d;
      if (m_pend_code == 3'd6 && !st[0]) m_bus_id = m_pend_data[3:0];
      m_irq = m_ie; m_busy = 1'b0;
    end
    check("irq_after_done", {7'd0, irq}, {7'd0, m_irq});
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    logic [7:0] q, d;
    logic [2:0] c;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {7'd0, ack}, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'h00);
    check("rst_core_en", {7'd0, core_en}, 8'h00);
    check("rst_code", {5'd0, code}, 8'h00);
    check("rst_data", cdata, 8'h00);
    check("rst_dat_o", rdat, 8'h00);
    rst = 1'b1;
    wb_rd("rst_csr", 2'd0);
    wb_rd("rst_cmdr", 2'd2);

    wb_wr(2'd0, 8'hC0);
    check("core_en_on", {7'd0, core_en}, 8'h01);
    wb_rd("csr_c0", 2'd0);
    wb_wr(2'd3, 8'hFF);
    wb_rd("fsmr_ro", 2'd3);

    // SET_BUS 5 with a stalled handshake.
    wb_wr(2'd1, 8'h05);
    wb_wr(2'd2, 8'h06);
    grant(3);
    check("one_request", 8'(hs_count), 8'(m_reqs));
    pulse_done(4'b1000, 8'h00);
    wb_rd("csr_bus5", 2'd0);
    wb_rd("cmdr_86", 2'd2);
    check("irq_cleared", {7'd0, irq}, {7'd0, m_irq});

    // RD_NAK with received data and NAK status.
    wb_wr(2'd2, 8'h03);
    grant(0);
    pulse_done(4'b1100, 8'hA5);
    wb_rd("dpr_a5", 2'd1);
    wb_rd("cmdr_c3", 2'd2);
    wb_rd("cmdr_83", 2'd2);

    // Illegal code.
    wb_wr(2'd2, 8'h07);
    check("illegal_no_valid", {7'd0, valid}, 8'h00);
    check("illegal_irq", {7'd0, irq}, {7'd0, m_irq});
    wb_rd("cmdr_97", 2'd2);

    // Bus id out of range.
    wb_wr(2'd1, 8'h10);
    wb_wr(2'd2, 8'h06);
    check("badbus_no_valid", {7'd0, valid}, 8'h00);
    wb_rd("cmdr_badbus", 2'd2);

    // Second CMDR write while busy.
    wb_wr(2'd1, 8'h5A);
    wb_wr(2'd2, 8'h01);
    grant(1);
    wb_wr(2'd2, 8'h01);
    check("busy_wr_irq", {7'd0, irq}, {7'd0, m_irq});
    check("busy_wr_no_valid", {7'd0, valid}, 8'h00);
    check("busy_wr_single_req", 8'(hs_count), 8'(m_reqs));
    wb_rd("cmdr_busy_err", 2'd2);
    pulse_done(4'b1000, 8'h00);
    wb_rd("cmdr_after_busy", 2'd2);

    // Randomized command traffic.
    for (int it = 0; it < 24; it++) begin
      d = 8'($urandom_range(0, 20));
      c = 3'($urandom_range(0, 7));
      bb = 1'($urandom_range(0, 1));
      bc = 1'($urandom_range(0, 1));
      fsm_state = 8'($urandom);
      wb_wr(2'd1, d);
      wb_wr(2'd2, {5'd0, c});
      if (m_busy) begin
        grant(int'($urandom_range(0, 3)));
        pulse_done({1'b1, 3'($urandom_range(0, 7))}, 8'($urandom));
      end else begin
        check("rand_no_valid", {7'd0, valid}, 8'h00);
      end
      check("rand_irq", {7'd0, irq}, {7'd0, m_irq});
      check("rand_reqs", 8'(hs_count), 8'(m_reqs));
      wb_rd("rand_cmdr", 2'd2);
      wb_rd("rand_dpr", 2'd1);
      wb_rd("rand_csr", 2'd0);
      wb_rd("rand_fsmr", 2'd3);
    end
    bb = 1'b0; bc = 1'b0;

    // Abort while in REQ, then while in BUSY.
    wb_wr(2'd2, 8'h05);
    wb_wr(2'd0, 8'h00);
    check("abort_req_valid", {7'd0, valid}, 8'h00);
    wb_wr(2'd0, 8'hC0);
    wb_wr(2'd1, 8'h33);
    wb_wr(2'd2, 8'h04);
    grant(1);
    wb_wr(2'd0, 8'h00);
    check("abort_valid", {7'd0, valid}, 8'h00);
    check("abort_irq", {7'd0, irq}, 8'h00);
    check("abort_core_en", {7'd0, core_en}, 8'h00);
    pulse_done(4'b1000, 8'hEE);
    wb_rd("abort_cmdr", 2'd2);
    wb_rd("abort_csr", 2'd0);
    wb_rd("abort_dpr_kept", 2'd1);
    wb_wr(2'd2, 8'h01);
    check("disabled_no_valid", {7'd0, valid}, 8'h00);
    wb_rd("disabled_cmdr", 2'd2);
    check("abort_reqs", 8'(hs_count), 8'(m_reqs));

    // Reset arriving with a pending command and a WB request.
    wb_wr(2'd0, 8'hC0);
    wb_wr(2'd1, 8'h22);
    wb_wr(2'd2, 8'h01);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd0; rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ack", {7'd0, ack}, 8'h00);
    check("rst_mid_valid", {7'd0, valid}, 8'h00);
    check("rst_mid_core_en", {7'd0, core_en}, 8'h00);
    check("rst_mid_irq", {7'd0, irq}, 8'h00);
    check("rst_mid_code", {5'd0, code}, 8'h00);
    check("rst_mid_data", cdata, 8'h00);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    wb_rd("rst_mid_cmdr", 2'd2);
    wb_rd("rst_mid_csr", 2'd0);
    wb_rd("rst_mid_dpr", 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
